// File: rtl/sha256_channel_mux_if.sv
// Producer, engine and result buses shared between sha256_channel_mux and its environment.
interface sha256_channel_mux_if #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 512,
    parameter int HASH_W   = 256
);
    localparam int ID_W = $clog2(CHANNELS);

    logic [CHANNELS*DATA_W-1:0] s_data;
    logic [CHANNELS-1:0]        s_last;
    logic [CHANNELS-1:0]        s_valid;
    logic [CHANNELS-1:0]        s_ready;
    logic [DATA_W-1:0]          m_data;
    logic                       m_last;
    logic                       m_valid;
    logic                       m_ready;
    logic [HASH_W-1:0]          h_data;
    logic                       h_last;
    logic                       h_valid;
    logic                       h_ready;
    logic [HASH_W-1:0]          r_data;
    logic                       r_last;
    logic [ID_W-1:0]            r_id;
    logic [CHANNELS-1:0]        r_valid;
    logic [CHANNELS-1:0]        r_ready;

    modport slave (
        input  s_data, s_last, s_valid, m_ready, h_data, h_last, h_valid, r_ready,
        output s_ready, m_data, m_last, m_valid, h_ready, r_data, r_last, r_id, r_valid
    );

    modport master (
        output s_data, s_last, s_valid, m_ready, h_data, h_last, h_valid, r_ready,
        input  s_ready, m_data, m_last, m_valid, h_ready, r_data, r_last, r_id, r_valid
    );
endinterface

// File: rtl/sha256_channel_mux.sv
// Packet arbiter in front of a single SHA-256 engine, with an in-order tag FIFO steering hashes back.
// Define SHA256_CHANNEL_MUX_RR_EN for round-robin selection; otherwise the lowest requesting channel wins.
module sha256_channel_mux #(
    parameter int CHANNELS  = 4,
    parameter int DATA_W    = 512,
    parameter int HASH_W    = 256,
    parameter int TAG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic                 en,
    output logic                 err,
    sha256_channel_mux_if.slave  bus
);
    localparam int ID_W  = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   tag_mem_q [TAG_DEPTH];
    logic [ID_W-1:0]   tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              err_q, err_d;

    logic              push_s;
    logic              pop_s;
    logic              empty_s;
    logic              full_s;
    logic              last_hs_s;
    logic [ID_W-1:0]   head_s;
    logic [ID_W-1:0]   sel_s;
    logic [ID_W-1:0]   scan_start_s;
`ifdef SHA256_CHANNEL_MUX_RR_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // First requester at or after start, scanning upward with wrap.
    function automatic logic [ID_W-1:0] pick_channel(input logic [CHANNELS-1:0] req,
                                                     input logic [ID_W-1:0]     start);
        logic [ID_W-1:0] res;
        logic            found;
        int              idx;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(start) + k) % CHANNELS;
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

`ifdef SHA256_CHANNEL_MUX_RR_EN
    assign scan_start_s = rr_ptr_q;
`else
    assign scan_start_s = '0;
`endif
    assign sel_s   = pick_channel(bus.s_valid, scan_start_s);
    assign empty_s = (count_q == {(PTR_W+1){1'b0}});
    assign full_s  = (count_q == (PTR_W+1)'(TAG_DEPTH));
    assign head_s  = tag_mem_q[rd_ptr_q];
    assign err     = err_q;

    // Arbiter: grant a whole packet, then pass the granted channel's beats to the engine.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        push_s      = 1'b0;
`ifdef SHA256_CHANNEL_MUX_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        last_hs_s   = en & bus.s_valid[grant_q] & bus.m_ready & bus.s_last[grant_q];
        bus.m_data  = bus.s_data[int'(grant_q)*DATA_W +: DATA_W];
        bus.m_last  = bus.s_last[grant_q];
        bus.m_valid = 1'b0;
        bus.s_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (en && (|bus.s_valid) && !full_s) begin
                    grant_d = sel_s;
                    push_s  = 1'b1;
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                bus.m_valid          = en & bus.s_valid[grant_q];
                bus.s_ready[grant_q] = en & bus.m_ready;
                if (last_hs_s) begin
                    state_d = ST_IDLE;
`ifdef SHA256_CHANNEL_MUX_RR_EN
                    rr_ptr_d = (grant_q == ID_W'(CHANNELS - 1)) ? '0 : grant_q + ID_W'(1);
`endif
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Return path: hash goes to the channel at the tag FIFO head, pop on its last beat.
    always_comb begin
        bus.r_data          = bus.h_data;
        bus.r_last          = bus.h_last;
        bus.r_id            = empty_s ? '0 : head_s;
        bus.r_valid         = '0;
        bus.r_valid[head_s] = en & bus.h_valid & ~empty_s;
        bus.h_ready         = en & bus.r_ready[head_s] & ~empty_s;
        pop_s               = en & bus.h_valid & bus.r_ready[head_s] & ~empty_s & bus.h_last;
        err_d               = err_q | (en & bus.h_valid & empty_s);
    end

    // Tag FIFO next state; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            tag_mem_d[wr_ptr_q] = sel_s;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; the next-state logic already holds everything while en is low.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
`ifdef SHA256_CHANNEL_MUX_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
`ifdef SHA256_CHANNEL_MUX_RR_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_sha256_channel_mux.sv
// Bench for sha256_channel_mux: directed scenarios plus random traffic against a packet/queue model.
module tb_sha256_channel_mux;
    localparam int C  = 4;
    localparam int DW = 32;
    localparam int HW = 16;
    localparam int TD = 2;
`ifdef SHA256_CHANNEL_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk, sync_rst, en, err;
    int   n_total, n_bad;

    // Model: current packet owner (-1 when none), outstanding tags in grant order, sticky error, scan start.
    int   owner;
    int   tags[$];
    bit   m_err;
    int   rr;
    int   obs[$];
    logic e_mvalid, e_hready;
    logic [C-1:0] e_sready, e_rvalid, last_hs;

    sha256_channel_mux_if #(.CHANNELS(C), .DATA_W(DW), .HASH_W(HW)) bus ();

    sha256_channel_mux #(.CHANNELS(C), .DATA_W(DW), .HASH_W(HW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .sync_rst(sync_rst), .en(en), .err(err), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [C-1:0] req, input int start);
        for (int k = 0; k < C; k++) begin
            if (req[(start + k) % C]) return (start + k) % C;
        end
        return 0;
    endfunction

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic step();
        bit ne, pop, do_push;
        int head, g;
        #1;
        ne   = (tags.size() > 0);
        head = ne ? tags[0] : 0;
        e_mvalid = 1'b0;
        e_sready = '0;
        if (owner >= 0) begin
            e_mvalid        = en & bus.s_valid[owner];
            e_sready[owner] = en & bus.m_ready;
        end
        e_rvalid       = '0;
        e_rvalid[head] = en & bus.h_valid & ne;
        e_hready       = en & ne & bus.r_ready[head];
        check_eq("m_valid", bus.m_valid, e_mvalid);
        check_eq("s_ready", bus.s_ready, e_sready);
        check_eq("r_valid", bus.r_valid, e_rvalid);
        check_eq("h_ready", bus.h_ready, e_hready);
        check_eq("err", err, m_err);
        check_eq("r_data", bus.r_data, bus.h_data);
        check_eq("r_last", bus.r_last, bus.h_last);
        if (ne) check_eq("r_id", bus.r_id, head);
        if (e_mvalid) begin
            check_eq("m_data", bus.m_data, bus.s_data[owner*DW +: DW]);
            check_eq("m_last", bus.m_last, bus.s_last[owner]);
        end
        last_hs = bus.s_valid & bus.s_ready;
        @(posedge clk);
        if (sync_rst) begin
            owner = -1;
            tags.delete();
            m_err = 1'b0;
            rr    = 0;
        end else if (en) begin
            do_push = 1'b0;
            g       = 0;
            pop     = e_hready && bus.h_valid && bus.h_last;
            if (owner < 0) begin
                if (bus.s_valid != '0 && tags.size() < TD) begin
                    g       = pick(bus.s_valid, RR ? rr : 0);
                    owner   = g;
                    do_push = 1'b1;
                end
            end else if (e_mvalid && bus.m_ready && bus.s_last[owner]) begin
                rr    = (owner + 1) % C;
                owner = -1;
            end
            if (bus.h_valid && !ne) m_err = 1'b1;
            if (pop) void'(tags.pop_front());
            if (do_push) tags.push_back(g);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.s_valid = '0;
        bus.r_ready = '1;
        bus.h_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.h_valid = (tags.size() > 0);
            step();
        end
        bus.h_valid = 1'b0;
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
    endtask

    initial begin
        logic [C-1:0] mr_seq;
        n_total = 0; n_bad = 0; owner = -1; rr = 0; m_err = 1'b0; last_hs = '0;
        sync_rst = 1'b1; en = 1'b1;
        bus.s_data = '0; bus.s_last = '0; bus.s_valid = '0; bus.m_ready = 1'b0;
        bus.h_data = '0; bus.h_last = 1'b0; bus.h_valid = 1'b0; bus.r_ready = '0;
        @(posedge clk);
        @(negedge clk);
        sync_rst = 1'b0;
        #1;
        check_eq("rst_m_valid", bus.m_valid, 1'b0);
        check_eq("rst_s_ready", bus.s_ready, 4'b0000);
        check_eq("rst_r_valid", bus.r_valid, 4'b0000);
        check_eq("rst_h_ready", bus.h_ready, 1'b0);
        check_eq("rst_r_id", bus.r_id, 2'd0);
        check_eq("rst_err", err, 1'b0);
        step();

        // ch2 two-beat packet, then its hash comes back
        bus.s_valid = 4'b0100; bus.s_last = 4'b0000; bus.m_ready = 1'b1;
        bus.s_data[2*DW +: DW] = 32'hA1A1_0001;
        step();
        #1;
        check_eq("a_mvalid1", bus.m_valid, 1'b1);
        check_eq("a_mdata1", bus.m_data, 32'hA1A1_0001);
        check_eq("a_mlast1", bus.m_last, 1'b0);
        step();
        bus.s_data[2*DW +: DW] = 32'hA1A1_0002; bus.s_last = 4'b0100;
        #1;
        check_eq("a_mdata2", bus.m_data, 32'hA1A1_0002);
        check_eq("a_mlast2", bus.m_last, 1'b1);
        step();
        bus.s_valid = '0; bus.s_last = '0;
        bus.h_valid = 1'b1; bus.h_last = 1'b1; bus.h_data = 16'h5A5A; bus.r_ready = 4'b0100;
        #1;
        check_eq("a_r_id", bus.r_id, 2'd2);
        check_eq("a_r_valid", bus.r_valid, 4'b0100);
        check_eq("a_h_ready", bus.h_ready, 1'b1);
        step();
        bus.h_valid = 1'b0;
        #1;
        check_eq("a_popped", bus.h_ready, 1'b0);
        step();

        // hash with no outstanding tag sets a sticky error
        bus.h_valid = 1'b1; bus.r_ready = '1;
        #1;
        check_eq("e_h_ready", bus.h_ready, 1'b0);
        step();
        bus.h_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("e_sticky", err, 1'b1);
            step();
        end
        do_reset();
        #1;
        check_eq("e_cleared", err, 1'b0);

        // tag FIFO full blocks a third grant until a hash pops
        bus.r_ready = '0; bus.m_ready = 1'b1; bus.s_last = '1; bus.s_valid = 4'b0111;
        for (int c = 0; c < C; c++) bus.s_data[c*DW +: DW] = $urandom;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.s_valid = bus.s_valid & ~last_hs;
        end
        #1;
        check_eq("f_blocked_mv", bus.m_valid, 1'b0);
        check_eq("f_blocked_sr", bus.s_ready, 4'b0000);
        bus.h_valid = 1'b1; bus.h_last = 1'b1; bus.r_ready = '1;
        #1;
        check_eq("f_pop_cycle_mv", bus.m_valid, 1'b0);
        step();
        bus.h_valid = 1'b0;
        #1;
        check_eq("f_grant_cycle_mv", bus.m_valid, 1'b0);
        step();
        #1;
        check_eq("f_served_mv", bus.m_valid, 1'b1);
        check_eq("f_served_sr", bus.s_ready, 4'b0100);
        step();
        drain();

        // all channels streaming 1-beat packets: observe grant order
        do_reset();
        bus.s_valid = '1; bus.s_last = '1; bus.m_ready = 1'b1; bus.r_ready = '1; bus.h_last = 1'b1;
        obs.delete();
        for (int i = 0; i < 12; i++) begin
            bus.h_valid = (tags.size() > 0);
            step();
            for (int c = 0; c < C; c++) if (last_hs[c]) obs.push_back(c);
        end
        check_eq("order_count", (obs.size() >= 5), 1'b1);
        for (int k = 0; k < 5 && k < obs.size(); k++)
            check_eq("order", obs[k], RR ? (k % C) : 0);
        drain();

        // ch1 mid-packet with m_ready stalls while ch3 waits
        do_reset();
        bus.r_ready = '0; bus.m_ready = 1'b1;
        bus.s_valid = 4'b1010; bus.s_last = 4'b1000;
        bus.s_data[1*DW +: DW] = 32'hD000_0000; bus.s_data[3*DW +: DW] = 32'hE000_0000;
        step();
        mr_seq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            bus.m_ready = mr_seq[i];
            if (i == 1) begin
                bus.s_data[1*DW +: DW] = 32'hD000_0001;
                bus.s_last[1] = 1'b1;
            end
            #1;
            check_eq("p_mdata", bus.m_data, bus.s_data[1*DW +: DW]);
            check_eq("p_sready3", bus.s_ready[3], 1'b0);
            step();
        end
        bus.s_valid[1] = 1'b0;
        #1;
        check_eq("p_bubble_mv", bus.m_valid, 1'b0);
        step();
        #1;
        check_eq("p_ch3_sready", bus.s_ready, 4'b1000);
        check_eq("p_ch3_mdata", bus.m_data, 32'hE000_0000);
        step();
        drain();

        // reset during beat 2 of a 4-beat ch0 packet
        bus.s_valid = 4'b0001; bus.s_last = '0; bus.m_ready = 1'b1; bus.r_ready = '1;
        bus.s_data[0*DW +: DW] = 32'hF000_0000;
        step();
        step();
        bus.s_data[0*DW +: DW] = 32'hF000_0001;
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        bus.s_valid = 4'b0010; bus.s_last = 4'b0010; bus.s_data[1*DW +: DW] = 32'h6000_0000;
        #1;
        check_eq("r_after_mv", bus.m_valid, 1'b0);
        check_eq("r_after_rv", bus.r_valid, 4'b0000);
        check_eq("r_after_tags", bus.h_ready, 1'b0);
        step();
        #1;
        check_eq("r_new_sready", bus.s_ready, 4'b0010);
        check_eq("r_new_mdata", bus.m_data, 32'h6000_0000);
        step();
        drain();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < C; c++) begin
                if (last_hs[c] || !bus.s_valid[c]) begin
                    bus.s_valid[c] = ($urandom_range(2) != 0);
                    bus.s_last[c]  = ($urandom_range(2) == 0);
                    bus.s_data[c*DW +: DW] = $urandom;
                end
            end
            en          = ($urandom_range(9) != 0);
            bus.m_ready = ($urandom_range(3) != 0);
            bus.h_valid = (tags.size() > 0) && ($urandom_range(1) != 0);
            bus.h_last  = ($urandom_range(1) != 0);
            bus.h_data  = HW'($urandom);
            bus.r_ready = C'($urandom);
            sync_rst    = ($urandom_range(199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
